// File: rtl/risc_toy_fetch_queue_if.sv
// Bus bundle linking the fetch queue to instruction memory, the EX redirect
// path and the decode handshake.
interface risc_toy_fetch_queue_if;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        REDIR;
  logic [29:0] REDIR_ADDR;
  logic        ID_VALID;
  logic        ID_READY;
  logic [31:0] ID_INSTR;
  logic [29:0] ID_PC;

  modport master (
    output IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC,
    input  INSTR, REDIR, REDIR_ADDR, ID_READY
  );

  modport slave (
    input  IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC,
    output INSTR, REDIR, REDIR_ADDR, ID_READY
  );
endinterface

// File: rtl/risc_toy_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues IMEM requests and buffers returned
// words in a first-word-fall-through queue for decode. FETCH_PERF_CNT_EN adds PERF_FETCH/PERF_STALL.
module risc_toy_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic CLK,
  input  logic RSTN,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] PERF_FETCH,
  output logic [31:0] PERF_STALL,
`endif
  risc_toy_fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [29:0]   fetch_pc;
  logic          run;
  logic          req_q;
  logic [29:0]   addr_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [29:0]   mem_pc    [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  logic          id_valid;

  // A slot is reserved for the in-flight request, so a response always finds room.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, req_q};
  assign issue     = run & ~bus.REDIR & (occupancy < (CW+1)'(DEPTH));
  assign push      = req_q & ~bus.REDIR;
  assign id_valid  = (count != '0) & ~bus.REDIR;
  assign pop       = id_valid & bus.ID_READY;

  assign bus.IREQ     = issue;
  assign bus.IADDR    = fetch_pc;
  assign bus.ID_VALID = id_valid;
  assign bus.ID_INSTR = mem_instr[rd_ptr];
  assign bus.ID_PC    = mem_pc[rd_ptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc <= RESET_PC;
      run      <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      run <= 1'b1;
      if (bus.REDIR) begin
        // Flush: drop queued entries and the arriving response, restart fetch.
        fetch_pc <= bus.REDIR_ADDR;
        req_q    <= 1'b0;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        req_q <= issue;
        if (issue) begin
          addr_q   <= fetch_pc;
          fetch_pc <= fetch_pc + 30'd1;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= bus.INSTR;
      mem_pc[wr_ptr]    <= addr_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PERF_FETCH <= '0;
      PERF_STALL <= '0;
    end else begin
      if (pop) PERF_FETCH <= PERF_FETCH + 32'd1;
      if (bus.ID_READY & ~id_valid & ~bus.REDIR) PERF_STALL <= PERF_STALL + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Self-checking bench for risc_toy_fetch_queue: scoreboard of expected decode
// transfers plus per-cycle checks of the fetch request stream.
module tb_risc_toy_fetch_queue;
  localparam logic [29:0] WRAP_PC = 30'h3FFFFFFE;

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;
  always #5 CLK = ~CLK;

  risc_toy_fetch_queue_if b0 ();
  risc_toy_fetch_queue_if b1 ();

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  logic [61:0] sb [$];
  logic [61:0] sb_exp;
  bit          sb_en = 1'b0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch0, perf_stall0, perf_fetch1, perf_stall1;
`endif

  risc_toy_fetch_queue #(.DEPTH(4), .RESET_PC(30'h0)) dut0 (
    .CLK(CLK),
    .RSTN(RSTN),
`ifdef FETCH_PERF_CNT_EN
    .PERF_FETCH(perf_fetch0),
    .PERF_STALL(perf_stall0),
`endif
    .bus(b0)
  );

  risc_toy_fetch_queue #(.DEPTH(4), .RESET_PC(WRAP_PC)) dut1 (
    .CLK(CLK),
    .RSTN(RSTN),
`ifdef FETCH_PERF_CNT_EN
    .PERF_FETCH(perf_fetch1),
    .PERF_STALL(perf_stall1),
`endif
    .bus(b1)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b01, a ^ 30'h0155_AA33};
  endfunction

  // Instruction memory: data returns the cycle after the request.
  always @(posedge CLK) if (b0.IREQ === 1'b1) b0.INSTR <= mem_word(b0.IADDR);
  always @(posedge CLK) if (b1.IREQ === 1'b1) b1.INSTR <= mem_word(b1.IADDR);

  // Decode-side monitor: every transfer must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (sb_en && RSTN) begin
      tests_run++;
      if (dut0.count > 3'd4) begin
        tests_failed++;
        $display("FAIL count_bound: count=%0d max=4", dut0.count);
      end
      if (b0.ID_VALID === 1'b1 && b0.ID_READY === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_transfer: pc=%h instr=%h, none expected", b0.ID_PC, b0.ID_INSTR);
        end else begin
          sb_exp = sb.pop_front();
          $display("[TB] cycle %0d transfer pc=%h instr=%h", cyc, b0.ID_PC, b0.ID_INSTR);
          if ({b0.ID_INSTR, b0.ID_PC} !== sb_exp) begin
            tests_failed++;
            $display("FAIL transfer: got pc=%h instr=%h, expected pc=%h instr=%h",
                     b0.ID_PC, b0.ID_INSTR, sb_exp[29:0], sb_exp[61:30]);
          end
        end
      end
    end
  end

  task automatic sb_push_range(input logic [29:0] start, input int n);
    logic [29:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back({mem_word(p), p});
      p = p + 30'd1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Hold reset for two edges; returns in cycle 0 right after release.
  task automatic apply_reset(input logic ready);
    @(posedge CLK);
    #1;
    RSTN = 1'b0;
    b0.REDIR = 1'b0;
    b0.ID_READY = ready;
    sb_en = 1'b0;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    cyc = 0;
  endtask

  task automatic drain_check(input string name);
    @(negedge CLK);
    #1;
    sb_en = 1'b0;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d expected transfers missing, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #1 RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    tests_run++;
    if (b0.IREQ !== 1'b0 || b0.ID_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: IREQ=%b ID_VALID=%b, required 0 0", b0.IREQ, b0.ID_VALID);
    end
    tests_run++;
    if (b0.IADDR !== 30'h0 || b0.ID_INSTR !== 32'h0 || b0.ID_PC !== 30'h0) begin
      tests_failed++;
      $display("FAIL reset_data: IADDR=%h ID_INSTR=%h ID_PC=%h, required 0 0 0", b0.IADDR, b0.ID_INSTR, b0.ID_PC);
    end
    tests_run++;
    if (b1.IADDR !== WRAP_PC || b1.IREQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pc_param: IADDR=%h IREQ=%b, required %h 0", b1.IADDR, b1.IREQ, WRAP_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    sb_push_range(30'h0, 18);
    sb_en = 1'b1;
    #3;
    tests_run++;
    if (b0.IREQ !== 1'b0 || b0.ID_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_cycle0: IREQ=%b ID_VALID=%b, required 0 0", b0.IREQ, b0.ID_VALID);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      #3;
      tests_run++;
      if (b0.IREQ !== 1'b1 || b0.IADDR !== 30'(k - 1)) begin
        tests_failed++;
        $display("FAIL stream_issue c%0d: IREQ=%b IADDR=%h, required 1 %h", k, b0.IREQ, b0.IADDR, 30'(k - 1));
      end
      tests_run++;
      if (b0.ID_VALID !== (k >= 3)) begin
        tests_failed++;
        $display("FAIL stream_valid c%0d: ID_VALID=%b, required %b", k, b0.ID_VALID, (k >= 3));
      end
    end
    drain_check("stream");
  endtask

  task automatic test_reset_mid();
    #1 RSTN = 1'b0;
    #1;
    tests_run++;
    if (b0.ID_VALID !== 1'b0 || b0.IREQ !== 1'b0 || b0.IADDR !== 30'h0 ||
        b0.ID_INSTR !== 32'h0 || b0.ID_PC !== 30'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: VALID=%b IREQ=%b IADDR=%h INSTR=%h PC=%h, required all 0",
               b0.ID_VALID, b0.IREQ, b0.IADDR, b0.ID_INSTR, b0.ID_PC);
    end
    apply_reset(1'b1);
    sb_push_range(30'h0, 3);
    sb_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      #3;
      tests_run++;
      if (b0.ID_VALID !== (k >= 3)) begin
        tests_failed++;
        $display("FAIL reset_mid_valid c%0d: ID_VALID=%b, required %b", k, b0.ID_VALID, (k >= 3));
      end
    end
    drain_check("reset_mid");
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    sb_push_range(30'h0, 12);
    sb_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 9) b0.ID_READY = 1'b1;
      #3;
      if (k <= 8) begin
        tests_run++;
        if (b0.IREQ !== (k <= 4) || b0.ID_VALID !== (k >= 3)) begin
          tests_failed++;
          $display("FAIL bp_stall c%0d: IREQ=%b ID_VALID=%b, required %b %b", k, b0.IREQ, b0.ID_VALID, (k <= 4), (k >= 3));
        end
        if (k >= 3) begin
          tests_run++;
          if (b0.ID_PC !== 30'h0 || b0.ID_INSTR !== mem_word(30'h0)) begin
            tests_failed++;
            $display("FAIL bp_hold c%0d: ID_PC=%h ID_INSTR=%h, required 0 %h", k, b0.ID_PC, b0.ID_INSTR, mem_word(30'h0));
          end
        end
      end else begin
        tests_run++;
        if (b0.ID_VALID !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_gap c%0d: ID_VALID=%b, required 1", k, b0.ID_VALID);
        end
      end
      if (k == 8) begin
        tests_run++;
        if (dut0.count !== 3'd4) begin
          tests_failed++;
          $display("FAIL bp_full: count=%0d, required 4", dut0.count);
        end
      end
    end
    drain_check("backpressure");
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    sb_push_range(30'h0, 5);
    sb_en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      b0.ID_READY   = ((k >= 9 && k <= 13) || k >= 16);
      b0.REDIR      = (k == 15);
      b0.REDIR_ADDR = 30'h100;
      if (k == 15) begin
        sb.delete();
        sb_push_range(30'h100, 5);
      end
      #3;
      if (k == 14) begin
        tests_run++;
        if (b0.IREQ !== 1'b1 || b0.IADDR !== 30'h8) begin
          tests_failed++;
          $display("FAIL redir_setup: IREQ=%b IADDR=%h, required 1 8", b0.IREQ, b0.IADDR);
        end
      end
      if (k == 15) begin
        tests_run++;
        if (b0.ID_PC !== 30'h5 || dut0.count !== 3'd3 || b0.ID_VALID !== 1'b0 || b0.IREQ !== 1'b0) begin
          tests_failed++;
          $display("FAIL redir_cycle: PC=%h count=%0d VALID=%b IREQ=%b, required 5 3 0 0",
                   b0.ID_PC, dut0.count, b0.ID_VALID, b0.IREQ);
        end
      end
      if (k == 16) begin
        tests_run++;
        if (b0.IREQ !== 1'b1 || b0.IADDR !== 30'h100 || b0.ID_VALID !== 1'b0) begin
          tests_failed++;
          $display("FAIL redir_restart: IREQ=%b IADDR=%h VALID=%b, required 1 100 0", b0.IREQ, b0.IADDR, b0.ID_VALID);
        end
      end
      if (k == 17) begin
        tests_run++;
        if (b0.ID_VALID !== 1'b0) begin
          tests_failed++;
          $display("FAIL redir_gap: ID_VALID=%b, required 0", b0.ID_VALID);
        end
      end
      if (k == 18) begin
        tests_run++;
        if (b0.ID_VALID !== 1'b1 || b0.ID_PC !== 30'h100) begin
          tests_failed++;
          $display("FAIL redir_first: VALID=%b PC=%h, required 1 100", b0.ID_VALID, b0.ID_PC);
        end
      end
    end
    b0.REDIR = 1'b0;
    drain_check("redirect");
  endtask

  task automatic test_redir_ready();
    apply_reset(1'b0);
    sb_push_range(30'h0, 3);
    sb_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      b0.ID_READY   = (k >= 9);
      b0.REDIR      = (k == 12);
      b0.REDIR_ADDR = 30'h200;
      if (k == 12) begin
        sb.delete();
        sb_push_range(30'h200, 6);
      end
      #3;
      if (k == 12) begin
        tests_run++;
        if (dut0.count !== 3'd2 || b0.ID_VALID !== 1'b0) begin
          tests_failed++;
          $display("FAIL redir_ready: count=%0d VALID=%b, required 2 0", dut0.count, b0.ID_VALID);
        end
      end
      if (k == 13) begin
        tests_run++;
        if (b0.IREQ !== 1'b1 || b0.IADDR !== 30'h200) begin
          tests_failed++;
          $display("FAIL redir_ready_restart: IREQ=%b IADDR=%h, required 1 200", b0.IREQ, b0.IADDR);
        end
      end
      if (k == 15) begin
        tests_run++;
        if (b0.ID_VALID !== 1'b1 || b0.ID_PC !== 30'h200) begin
          tests_failed++;
          $display("FAIL redir_ready_first: VALID=%b PC=%h, required 1 200", b0.ID_VALID, b0.ID_PC);
        end
      end
    end
    b0.REDIR = 1'b0;
    drain_check("redir_ready");
  endtask

  task automatic test_wrap();
    logic [29:0] ea;
    logic [29:0] ep;
    apply_reset(1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      #3;
      ea = WRAP_PC + 30'(k - 1);
      tests_run++;
      if (b1.IREQ !== 1'b1 || b1.IADDR !== ea) begin
        tests_failed++;
        $display("FAIL wrap_iaddr c%0d: IREQ=%b IADDR=%h, required 1 %h", k, b1.IREQ, b1.IADDR, ea);
      end
      if (k >= 3) begin
        ep = WRAP_PC + 30'(k - 3);
        tests_run++;
        if (b1.ID_VALID !== 1'b1 || b1.ID_PC !== ep || b1.ID_INSTR !== mem_word(ep)) begin
          tests_failed++;
          $display("FAIL wrap_pc c%0d: VALID=%b PC=%h INSTR=%h, required 1 %h %h",
                   k, b1.ID_VALID, b1.ID_PC, b1.ID_INSTR, ep, mem_word(ep));
        end
      end
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset(1'b0);
    sb_push_range(30'h0, 7);
    sb_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      b0.ID_READY   = (k <= 9);
      b0.REDIR      = (k == 10);
      b0.REDIR_ADDR = 30'h300;
      if (k == 10) sb.delete();
      #3;
      if (k >= 10) begin
        tests_run++;
        if (perf_fetch0 !== 32'd7 || perf_stall0 !== 32'd2) begin
          tests_failed++;
          $display("FAIL perf c%0d: PERF_FETCH=%0d PERF_STALL=%0d, required 7 2", k, perf_fetch0, perf_stall0);
        end
      end
    end
    b0.REDIR = 1'b0;
    sb_en = 1'b0;
  endtask
`endif

  initial begin
    b0.REDIR = 1'b0;
    b0.REDIR_ADDR = 30'h0;
    b0.ID_READY = 1'b1;
    b1.REDIR = 1'b0;
    b1.REDIR_ADDR = 30'h0;
    b1.ID_READY = 1'b1;
    test_reset();
    test_stream();
    test_reset_mid();
    test_backpressure();
    test_redirect();
    test_redir_ready();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/risc_toy_fetch_queue.md
Name: risc_toy_fetch_queue

Overview:
Instruction-fetch front end for the RISC_TOY 5-stage pipeline, sitting directly upstream of decode. It owns the fetch PC and drives the instruction-memory request (IREQ/IADDR), whose read data (INSTR) returns exactly one cycle after the request. Fetched words are buffered in a small first-word-fall-through queue and handed to decode over a valid/ready handshake. A redirect input from the execute stage (taken branch or jump) flushes the queue and restarts fetch at a new address.

Parameters:
DEPTH, 4, queue entries; power of 2, at least 2; full 1-instr/cycle throughput requires at least 3
RESET_PC, 30'h0, word address of the first fetch after reset

Ports:
CLK  input  1  clock, all state on posedge
RSTN  input  1  asynchronous active-low reset
IREQ  output  1  instruction-memory request this cycle
IADDR  output  30  word address of the request
INSTR  input  32  read data; valid the cycle after IREQ=1
REDIR  input  1  flush and restart fetch (from EX)
REDIR_ADDR  input  30  restart word address, sampled when REDIR=1
ID_VALID  output  1  head entry valid toward decode
ID_READY  input  1  decode accepts head entry
ID_INSTR  output  32  head instruction word
ID_PC  output  30  word address of ID_INSTR

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTN is asynchronous and active-low.
- State: fetch_pc[29:0]; run flag; req_q (request in flight); addr_q[29:0] (address of the in-flight request); queue of DEPTH x {32b instr, 30b pc} with rd_ptr, wr_ptr and count.
- Reset (asynchronous) clears all state:
  - fetch_pc=RESET_PC, run=0, req_q=0, count=0, both pointers 0.
  - Outputs during reset: IREQ=0, ID_VALID=0, IADDR=RESET_PC, ID_INSTR=0, ID_PC=0.
  - The queue storage RAM is also cleared.
  - Reset asserted mid-operation discards the queue and any in-flight request.
- run is set on the first clock edge after RSTN deasserts, so the first IREQ is issued one cycle after release.
- IREQ (combinational) = run & ~REDIR & (count + req_q < DEPTH).
  - IADDR = fetch_pc at all times.
- Issue: when IREQ=1, the edge sets req_q=1, addr_q=fetch_pc, fetch_pc=fetch_pc+1. The increment is modulo 2^30, so 30'h3FFFFFFF wraps to 0.
- Response: in the cycle where req_q=1, {INSTR, addr_q} is pushed at wr_ptr unless REDIR=1 in that same cycle.
- Redirect (REDIR=1), at the edge:
  - count=0 and rd_ptr=wr_ptr (flush);
  - fetch_pc=REDIR_ADDR;
  - the arriving response is discarded;
  - req_q=0.
  - REDIR has priority over push, pop and issue.
- Handshake:
  - ID_VALID = (count != 0) & ~REDIR.
  - Pop occurs when ID_VALID & ID_READY.
  - ID_INSTR and ID_PC show the head entry combinationally (FWFT) and are held stable while ID_VALID=1 and ID_READY=0.
  - Because ID_VALID is forced low during REDIR, a head entry presented in a REDIR cycle is never transferred.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow is impossible by construction of the IREQ rule. The bench asserts count <= DEPTH.
- Latency: IREQ in cycle k; entry visible with ID_VALID=1 in cycle k+2.
  - Steady state (DEPTH >= 3, ID_READY=1): one instruction per cycle.
  - REDIR in cycle r: first IREQ to REDIR_ADDR in cycle r+1; ID_VALID in cycle r+3.
- Empty queue with no request in flight: ID_VALID=0; IREQ continues to issue if run=1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - PERF_FETCH [31:0]: incremented on each pop.
  - PERF_STALL [31:0]: incremented on each cycle with ID_READY=1 & ID_VALID=0 & ~REDIR.
  - Both reset to 0, wrap modulo 2^32, and are not cleared by REDIR.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset release with ID_READY=1 and a memory model returning INSTR={2'b0,addr}: IADDR=0,1,2,... on consecutive cycles from cycle 1; ID_VALID=1 from cycle 3 with ID_PC=0,1,2,... and ID_INSTR matching, one per cycle, no gaps.
- ID_READY=0 from cycle 0 (DEPTH=4): IREQ drops after 4 requests, count=4, ID_PC held at 0. Raising ID_READY drains 0,1,2,3 in order, then 4,5,... with no duplicates or holes.
- Queue holding PCs 5,6,7 with a response for 8 in flight, then REDIR=1 with REDIR_ADDR=30'h100: ID_VALID=0 that cycle, response 8 dropped, IADDR=30'h100 next cycle, first delivered ID_PC=30'h100 with no stale PC delivered afterward.
- REDIR coincident with ID_READY=1 and count=2: no transfer occurs that cycle; no old-path entry ever appears on ID_PC.
- RESET_PC=30'h3FFFFFFE: IADDR sequence 3FFFFFFE, 3FFFFFFF, 0, 1; ID_PC follows the same wrap.
- FETCH_PERF_CNT_EN defined, 10 cycles of scenario 1 after reset: PERF_FETCH equals the number of pops; PERF_STALL=2 for the initial empty cycles 1 and 2.
